// File: rtl/data_read_capture_pkg.sv
// Shared definitions for the data_read capture path. The AXI read-side mux
// uses the same FSM encoding and status bit positions.
package data_read_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_e;

  localparam int SR_BUSY_BIT = 0;
  localparam int SR_DONE_BIT = 1;
  localparam int SR_OVF_BIT  = 2;

  function automatic int fifo_addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_read_capture_fifo.sv
// Synchronous first-word-fall-through FIFO with flush. The level counter
// carries one extra bit so that full and empty can be told apart.
module data_read_fifo
  import data_read_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  input  logic                                   push_i,
  input  logic [DATA_WIDTH-1:0]                  din_i,
  input  logic                                   pop_i,
  output logic [DATA_WIDTH-1:0]                  dout_o,
  output logic                                   empty_o,
  output logic [fifo_addr_width(FIFO_DEPTH):0]   level_o
);

  localparam int AW = fifo_addr_width(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_ZERO = (AW + 1)'(0);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           level_q;
  logic                  do_push;
  logic                  do_pop;

  // A flush wins over any push or pop issued in the same cycle.
  always_comb begin
    do_pop  = 1'b0;
    do_push = 1'b0;
    if (!flush_i) begin
      do_pop  = pop_i && (level_q != LVL_ZERO);
      do_push = push_i && ((level_q != LVL_FULL) || do_pop);
    end else begin
      do_pop  = 1'b0;
      do_push = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= LVL_ZERO;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (level_q == LVL_ZERO);
  assign level_o = level_q;

endmodule

// File: rtl/data_read_capture.sv
// Capture engine: on an accepted start, flushes the FIFO and stores the
// programmed number of samples from the parallel port, tracking busy/done/ovf.
module data_read_capture
  import data_read_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESET,
  input  logic                                 cr_start,
  input  logic [CNT_WIDTH-1:0]                 cr_count,
  input  logic [DATA_WIDTH-1:0]                din,
  input  logic                                 din_valid,
  input  logic                                 fifo_rd,
  output logic [DATA_WIDTH-1:0]                fifo_dout,
  output logic                                 fifo_empty,
  output logic [fifo_addr_width(FIFO_DEPTH):0] fifo_level,
  output logic                                 sr_busy,
  output logic                                 sr_done,
  output logic                                 sr_ovf
);

  localparam int AW = fifo_addr_width(FIFO_DEPTH);
  localparam logic [AW:0]          LVL_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  cap_state_e           state_q;
  logic [CNT_WIDTH-1:0] rem_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_q;
  logic                 accept_start;
  logic                 sample_store;

  // A sample fits if the FIFO has room or the head leaves in the same cycle.
  always_comb begin
    accept_start = 1'b0;
    sample_store = 1'b0;
    if (cr_start && (state_q != ST_CAPTURE)) begin
      accept_start = 1'b1;
    end else begin
      accept_start = 1'b0;
    end
    if ((state_q == ST_CAPTURE) && din_valid &&
        ((fifo_level != LVL_FULL) || (fifo_rd && !fifo_empty))) begin
      sample_store = 1'b1;
    end else begin
      sample_store = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q <= ST_IDLE;
      rem_q   <= CNT_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_start) begin
            rem_q <= cr_count;
            ovf_q <= 1'b0;
            if (cr_count == CNT_ZERO) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_CAPTURE;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        ST_CAPTURE: begin
          // Every valid sample is counted, stored or not.
          if (din_valid) begin
            rem_q <= rem_q - CNT_ONE;
            if (!sample_store) ovf_q <= 1'b1;
            if (rem_q == CNT_ONE) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end
      endcase
    end
  end

  data_read_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (S_AXI_ACLK),
    .rst_i   (S_AXI_ARESET),
    .flush_i (accept_start),
    .push_i  (sample_store),
    .din_i   (din),
    .pop_i   (fifo_rd),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign sr_busy = busy_q;
  assign sr_done = done_q;
  assign sr_ovf  = ovf_q;

endmodule

// File: tb/tb_data_read_capture.sv
// Scoreboard bench for data_read_capture: a queue-based reference model
// predicts status and popped data; a negedge monitor compares.
module tb_data_read_capture;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cr_start = 1'b0;
  logic [CW-1:0] cr_count = '0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          fifo_rd = 1'b0;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          sr_busy, sr_done, sr_ovf;

  always #5 clk = ~clk;

  data_read_capture #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .cr_start     (cr_start),
    .cr_count     (cr_count),
    .din          (din),
    .din_valid    (din_valid),
    .fifo_rd      (fifo_rd),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_level   (fifo_level),
    .sr_busy      (sr_busy),
    .sr_done      (sr_done),
    .sr_ovf       (sr_ovf)
  );

  // Reference model: stored samples, remaining count and status flags.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  int  m_rem = 0;
  bit  m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
  bit  chk_en = 1'b0;
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic model_step();
    int  sz;
    bit  pop_ok;
    if (rst) begin
      mq.delete();
      m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_rem = 0;
    end else begin
      pop_ok = fifo_rd && (mq.size() > 0);
      if (cr_start && !m_busy) begin
        mq.delete();
        m_ovf  = 1'b0;
        m_rem  = int'(cr_count);
        m_busy = (cr_count != 0);
        m_done = (cr_count == 0);
      end else begin
        sz = mq.size();
        if (pop_ok) void'(mq.pop_front());
        if (m_busy && din_valid) begin
          m_rem = m_rem - 1;
          if (sz < DEPTH || pop_ok) mq.push_back(din);
          else m_ovf = 1'b1;
          if (m_rem == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock: advance the model on the edge, then drive the next inputs.
  task automatic cycle(input bit r, input bit st, input int cnt,
                       input bit dv, input int d, input bit rd);
    @(posedge clk);
    model_step();
    #1;
    rst       = r;
    cr_start  = st;
    cr_count  = cnt[CW-1:0];
    din_valid = dv;
    din       = d[DW-1:0];
    fifo_rd   = rd;
    if (rd && mq.size() > 0) exp_q.push_back(mq[0]);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sr_busy",    int'(sr_busy),    int'(m_busy));
      chk("sr_done",    int'(sr_done),    int'(m_done));
      chk("sr_ovf",     int'(sr_ovf),     int'(m_ovf));
      chk("fifo_empty", int'(fifo_empty), int'(mq.size() == 0));
      chk("fifo_level", int'(fifo_level), mq.size());
      if (fifo_rd && exp_q.size() > 0) begin
        chk("fifo_dout", int'(fifo_dout), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    idle(2);

    // basic capture of 4 samples, then drain
    cycle(0, 1, 4, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, 0, 0, 1, i, 0);
    idle(2);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1);
    idle(1);

    // zero count
    cycle(0, 1, 0, 0, 0, 0);
    idle(3);

    // overflow with no pops
    cycle(0, 1, 6, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 16'h0010 + i, 0);
    idle(2);

    // full with simultaneous push and pop
    cycle(0, 1, 5, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 16'h0020 + i, 0);
    cycle(0, 0, 0, 1, 16'h00AA, 1);
    idle(2);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);

    // start while busy is ignored
    cycle(0, 1, 3, 0, 0, 0);
    cycle(0, 0, 0, 1, 16'h0031, 0);
    cycle(0, 1, 9, 1, 16'h0032, 0);
    cycle(0, 0, 0, 1, 16'h0033, 0);
    idle(2);

    // restart from DONE with 3 unread entries and ovf set
    cycle(0, 1, 6, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 16'h0040 + i, 0);
    cycle(0, 0, 0, 0, 0, 1);
    idle(1);
    cycle(0, 1, 2, 0, 0, 1);
    cycle(0, 0, 0, 1, 16'h0051, 0);
    cycle(0, 0, 0, 1, 16'h0052, 0);
    idle(2);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 0, 1);

    // reset mid-capture
    cycle(0, 1, 5, 0, 0, 0);
    cycle(0, 0, 0, 1, 16'h0061, 0);
    cycle(0, 0, 0, 1, 16'h0062, 0);
    cycle(1, 0, 0, 1, 16'h0063, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 16'h0070 + i, 0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 14) == 0,
            int'($urandom_range(0, 10)),
            $urandom_range(0, 9) < 7,
            int'($urandom_range(0, 16'hFFFF)),
            $urandom_range(0, 9) < 4);
    end
    idle(3);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
